// File: rtl/mor1kx_wb_commit_marocchino_pkg.sv
// Shared definitions for the MAROCCHINO write-back commit stage:
//   - OR1K_FPCSR_WIDTH, supervision register bit positions
//   - exception vector offsets (OR-ed with the exception base)
//   - commit FSM state type and the packed exception-flag bundle
package mor1kx_wb_commit_marocchino_pkg;

    localparam int OR1K_FPCSR_WIDTH = 12;

    // Supervision register bit positions
    localparam int SR_SM  = 0;
    localparam int SR_F   = 9;
    localparam int SR_CY  = 10;
    localparam int SR_OV  = 11;
    localparam int SR_DSX = 13;

    // Exception vector offsets
    localparam int EXCEPT_OFFSET_WIDTH = 12;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_BUS_ERR = 12'h200;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_DPF     = 12'h300;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_IPF     = 12'h400;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_ALIGN   = 12'h600;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_ILLEGAL = 12'h700;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_DTLB    = 12'h900;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_ITLB    = 12'hA00;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_SYSCALL = 12'hC00;
    localparam logic [EXCEPT_OFFSET_WIDTH-1:0] VECT_TRAP    = 12'hE00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXC_FLUSH,
        ST_RFE_FLUSH
    } commit_state_t;

    // One bit per exception source, listed in priority order (highest first)
    typedef struct packed {
        logic ibus_err;
        logic itlb_miss;
        logic ipagefault;
        logic ibus_align;
        logic illegal;
        logic syscall;
        logic dtlb_miss;
        logic dpagefault;
        logic align;
        logic dbus;
        logic trap;
    } wb_except_t;

endpackage

// File: rtl/mor1kx_except_prio_marocchino.sv
// Exception priority encoder: picks the highest-priority pending exception
// and returns its vector offset.
//   excepts    : pending exception flags
//   offset     : vector offset of the winning exception
//   is_syscall : the winning exception is a syscall (EPCR must skip it)
module mor1kx_except_prio_marocchino
    import mor1kx_wb_commit_marocchino_pkg::*;
(
    input  wb_except_t                     excepts,
    output logic [EXCEPT_OFFSET_WIDTH-1:0] offset,
    output logic                           is_syscall
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        offset     = VECT_TRAP;
        is_syscall = 1'b0;
        if      (excepts.ibus_err)   offset = VECT_BUS_ERR;
        else if (excepts.itlb_miss)  offset = VECT_ITLB;
        else if (excepts.ipagefault) offset = VECT_IPF;
        else if (excepts.ibus_align) offset = VECT_ALIGN;
        else if (excepts.illegal)    offset = VECT_ILLEGAL;
        else if (excepts.syscall) begin
            offset     = VECT_SYSCALL;
            is_syscall = 1'b1;
        end
        else if (excepts.dtlb_miss)  offset = VECT_DTLB;
        else if (excepts.dpagefault) offset = VECT_DPF;
        else if (excepts.align)      offset = VECT_ALIGN;
        else if (excepts.dbus)       offset = VECT_BUS_ERR;
    end

endmodule

// File: rtl/mor1kx_wb_commit_marocchino.sv
// Write-back commit stage: commits GPR writes and SR/FPCSR flag updates,
// takes exceptions and executes l.rfe, issuing a one-cycle pipeline flush
// plus PC redirect for each.
//   wb_*_i            : write-back stage result, PC and side-effect requests
//   rf_we/wadr/wdat_o : GPR write port (combinational from WB inputs)
//   sr/esr/epcr_o     : supervision, exception-saved SR and exception PC
//   atomic_flag_o     : load-link/store-conditional reservation flag
//   fpcsr_o           : floating-point control/status register
//   pipeline_flush_o, redirect_o, redirect_pc_o : flush/redirect request
module mor1kx_wb_commit_marocchino
    import mor1kx_wb_commit_marocchino_pkg::*;
#(
    parameter int          OPTION_OPERAND_WIDTH = 32,
    parameter int          OPTION_RF_ADDR_WIDTH = 5,
    parameter logic [31:0] OPTION_EXCEPT_BASE   = 32'h0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
    input  logic                            wb_rf_wb_i,
    input  logic                            wb_delay_slot_i,
    input  logic                            wb_op_rfe_i,
    input  logic                            wb_flag_set_i,
    input  logic                            wb_flag_clear_i,
    input  logic                            wb_atomic_flag_set_i,
    input  logic                            wb_atomic_flag_clear_i,
    input  logic                            wb_carry_set_i,
    input  logic                            wb_carry_clear_i,
    input  logic                            wb_overflow_set_i,
    input  logic                            wb_overflow_clear_i,
    input  logic [OR1K_FPCSR_WIDTH-1:0]     wb_fpcsr_i,
    input  logic                            wb_fpcsr_set_i,
    input  logic                            wb_except_ibus_err_i,
    input  logic                            wb_except_itlb_miss_i,
    input  logic                            wb_except_ipagefault_i,
    input  logic                            wb_except_ibus_align_i,
    input  logic                            wb_except_illegal_i,
    input  logic                            wb_except_syscall_i,
    input  logic                            wb_except_trap_i,
    input  logic                            wb_except_dtlb_miss_i,
    input  logic                            wb_except_dpagefault_i,
    input  logic                            wb_except_align_i,
    input  logic                            wb_except_dbus_i,
    input  logic                            wb_excepts_en_i,
    output logic                            rf_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wadr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rf_wdat_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] sr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] esr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] epcr_o,
    output logic                            atomic_flag_o,
    output logic [OR1K_FPCSR_WIDTH-1:0]     fpcsr_o,
    output logic                            pipeline_flush_o,
    output logic                            redirect_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o
);

    localparam logic [OPTION_OPERAND_WIDTH-1:0] EXCEPT_BASE = OPTION_OPERAND_WIDTH'(OPTION_EXCEPT_BASE);
    localparam logic [OPTION_OPERAND_WIDTH-1:0] INSN_BYTES  = OPTION_OPERAND_WIDTH'(4);
    localparam logic [OPTION_OPERAND_WIDTH-1:0] SR_RESET    = OPTION_OPERAND_WIDTH'(1) << SR_SM;

    commit_state_t                  state_q, state_d;
    wb_except_t                     excepts;
    logic [EXCEPT_OFFSET_WIDTH-1:0] except_offset;
    logic                           except_is_syscall;
    logic                           is_idle;
    logic                           except_take;
    logic                           rfe_take;

    assign excepts = '{
        ibus_err:   wb_except_ibus_err_i,
        itlb_miss:  wb_except_itlb_miss_i,
        ipagefault: wb_except_ipagefault_i,
        ibus_align: wb_except_ibus_align_i,
        illegal:    wb_except_illegal_i,
        syscall:    wb_except_syscall_i,
        dtlb_miss:  wb_except_dtlb_miss_i,
        dpagefault: wb_except_dpagefault_i,
        align:      wb_except_align_i,
        dbus:       wb_except_dbus_i,
        trap:       wb_except_trap_i
    };

    mor1kx_except_prio_marocchino u_except_prio (
        .excepts    (excepts),
        .offset     (except_offset),
        .is_syscall (except_is_syscall)
    );

    assign is_idle     = (state_q == ST_IDLE);
    assign except_take = is_idle & wb_excepts_en_i & (|excepts);
    // An exception in the same instruction overrides l.rfe.
    assign rfe_take    = is_idle & wb_op_rfe_i & ~except_take;

    assign rf_we_o   = wb_rf_wb_i & is_idle & ~except_take;
    assign rf_wadr_o = wb_rfd_adr_i;
    assign rf_wdat_o = wb_result_i;

    // State register; flush outputs decode from it directly, so an
    // asynchronous reset drops them in the same instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        // NOTE: sequential state always uses non-blocking assignment.
        else        state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        pipeline_flush_o = 1'b0;
        redirect_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (except_take)   state_d = ST_EXC_FLUSH;
                else if (rfe_take) state_d = ST_RFE_FLUSH;
            end
            ST_EXC_FLUSH, ST_RFE_FLUSH: begin
                pipeline_flush_o = 1'b1;
                redirect_o       = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_o          <= SR_RESET;
            esr_o         <= '0;
            epcr_o        <= '0;
            redirect_pc_o <= '0;
            atomic_flag_o <= 1'b0;
            fpcsr_o       <= '0;
        end else if (except_take) begin
            esr_o         <= sr_o;
            // Delay-slot faults restart at the branch; syscall resumes after itself.
            if (wb_delay_slot_i)        epcr_o <= pc_wb_i - INSN_BYTES;
            else if (except_is_syscall) epcr_o <= pc_wb_i + INSN_BYTES;
            else                        epcr_o <= pc_wb_i;
            sr_o[SR_SM]   <= 1'b1;
            sr_o[SR_DSX]  <= wb_delay_slot_i;
            atomic_flag_o <= 1'b0;
            redirect_pc_o <= EXCEPT_BASE | OPTION_OPERAND_WIDTH'(except_offset);
        end else if (is_idle) begin
            if (rfe_take) begin
                sr_o          <= esr_o;
                redirect_pc_o <= epcr_o;
                atomic_flag_o <= 1'b0;
            end else begin
                // Set wins over a simultaneous clear.
                if (wb_flag_set_i)            sr_o[SR_F]  <= 1'b1;
                else if (wb_flag_clear_i)     sr_o[SR_F]  <= 1'b0;
                if (wb_carry_set_i)           sr_o[SR_CY] <= 1'b1;
                else if (wb_carry_clear_i)    sr_o[SR_CY] <= 1'b0;
                if (wb_overflow_set_i)        sr_o[SR_OV] <= 1'b1;
                else if (wb_overflow_clear_i) sr_o[SR_OV] <= 1'b0;
                if (wb_atomic_flag_set_i)        atomic_flag_o <= 1'b1;
                else if (wb_atomic_flag_clear_i) atomic_flag_o <= 1'b0;
            end
            if (wb_fpcsr_set_i) fpcsr_o <= wb_fpcsr_i;
        end
    end

endmodule

// File: tb/tb_mor1kx_wb_commit_marocchino.sv
// Scoreboard bench for mor1kx_wb_commit_marocchino: stimulus pushes the
// expected GPR writes and redirects; a negedge monitor pops and compares.
module tb_mor1kx_wb_commit_marocchino;
    import mor1kx_wb_commit_marocchino_pkg::*;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epcr;
        logic [31:0] sr;
        logic [31:0] esr;
    } redir_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] wb_result, pc_wb;
    logic [4:0]  wb_rfd_adr;
    logic        wb_rf_wb, wb_delay_slot, wb_op_rfe;
    logic        flag_set, flag_clear, atomic_set, atomic_clear;
    logic        carry_set, carry_clear, ovf_set, ovf_clear;
    logic [OR1K_FPCSR_WIDTH-1:0] wb_fpcsr;
    logic        wb_fpcsr_set, excepts_en;
    wb_except_t  exc;

    logic        rf_we;
    logic [4:0]  rf_wadr;
    logic [31:0] rf_wdat, sr, esr, epcr, redirect_pc;
    logic        atomic_flag, pipeline_flush, redirect;
    logic [OR1K_FPCSR_WIDTH-1:0] fpcsr;

    int n_checks = 0;
    int n_pass   = 0;
    wr_t    exp_wr[$];
    redir_t exp_redir[$];

    always #5 clk = ~clk;

    mor1kx_wb_commit_marocchino dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .wb_result_i            (wb_result),
        .pc_wb_i                (pc_wb),
        .wb_rfd_adr_i           (wb_rfd_adr),
        .wb_rf_wb_i             (wb_rf_wb),
        .wb_delay_slot_i        (wb_delay_slot),
        .wb_op_rfe_i            (wb_op_rfe),
        .wb_flag_set_i          (flag_set),
        .wb_flag_clear_i        (flag_clear),
        .wb_atomic_flag_set_i   (atomic_set),
        .wb_atomic_flag_clear_i (atomic_clear),
        .wb_carry_set_i         (carry_set),
        .wb_carry_clear_i       (carry_clear),
        .wb_overflow_set_i      (ovf_set),
        .wb_overflow_clear_i    (ovf_clear),
        .wb_fpcsr_i             (wb_fpcsr),
        .wb_fpcsr_set_i         (wb_fpcsr_set),
        .wb_except_ibus_err_i   (exc.ibus_err),
        .wb_except_itlb_miss_i  (exc.itlb_miss),
        .wb_except_ipagefault_i (exc.ipagefault),
        .wb_except_ibus_align_i (exc.ibus_align),
        .wb_except_illegal_i    (exc.illegal),
        .wb_except_syscall_i    (exc.syscall),
        .wb_except_trap_i       (exc.trap),
        .wb_except_dtlb_miss_i  (exc.dtlb_miss),
        .wb_except_dpagefault_i (exc.dpagefault),
        .wb_except_align_i      (exc.align),
        .wb_except_dbus_i       (exc.dbus),
        .wb_excepts_en_i        (excepts_en),
        .rf_we_o                (rf_we),
        .rf_wadr_o              (rf_wadr),
        .rf_wdat_o              (rf_wdat),
        .sr_o                   (sr),
        .esr_o                  (esr),
        .epcr_o                 (epcr),
        .atomic_flag_o          (atomic_flag),
        .fpcsr_o                (fpcsr),
        .pipeline_flush_o       (pipeline_flush),
        .redirect_o             (redirect),
        .redirect_pc_o          (redirect_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_inputs();
        wb_result = '0; pc_wb = '0; wb_rfd_adr = '0;
        wb_rf_wb = 0; wb_delay_slot = 0; wb_op_rfe = 0;
        flag_set = 0; flag_clear = 0; atomic_set = 0; atomic_clear = 0;
        carry_set = 0; carry_clear = 0; ovf_set = 0; ovf_clear = 0;
        wb_fpcsr = '0; wb_fpcsr_set = 0; excepts_en = 0; exc = '0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one exception-or-RFE cycle, then idle through the flush cycle.
    task automatic event_cycle(input redir_t e);
        exp_redir.push_back(e);
        step();
        clear_inputs();
        step();
    endtask

    // Monitor: GPR writes and redirects are popped and compared mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: adr %0d dat %h, expected none", rf_wadr, rf_wdat);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("rf_wadr", 32'(rf_wadr), 32'(w.adr));
                    check("rf_wdat", rf_wdat, w.dat);
                end
            end
            if (redirect || pipeline_flush) begin
                if (exp_redir.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_redirect: pc %h flush %b, expected none", redirect_pc, pipeline_flush);
                end else begin
                    redir_t r;
                    r = exp_redir.pop_front();
                    check("flush_with_redirect", {31'b0, pipeline_flush}, {31'b0, redirect});
                    check("redirect_pc", redirect_pc, r.pc);
                    check("epcr", epcr, r.epcr);
                    check("sr", sr, r.sr);
                    check("esr", esr, r.esr);
                end
            end
        end
    end

    initial begin
        wb_except_t pv[8];
        logic [31:0] po[8];
        logic [31:0] pc;

        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("rst_sr", sr, 32'h1);
        check("rst_esr", esr, 32'h0);
        check("rst_epcr", epcr, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_fpcsr", 32'(fpcsr), 32'h0);
        check("rst_flags", {29'b0, atomic_flag, pipeline_flush, redirect}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Plain GPR write
        wb_rf_wb = 1; wb_rfd_adr = 5; wb_result = 32'hDEADBEEF;
        exp_wr.push_back('{adr: 5, dat: 32'hDEADBEEF});
        step(); clear_inputs();

        // Flag updates: set beats clear
        flag_set = 1; flag_clear = 1;
        step(); clear_inputs();
        check("flag_set_wins", sr, 32'h201);
        carry_set = 1;
        step(); clear_inputs();
        check("carry_set", sr, 32'h601);
        ovf_set = 1; carry_clear = 1;
        step(); clear_inputs();
        check("ovf_set_carry_clr", sr, 32'hA01);
        ovf_clear = 1;
        step(); clear_inputs();
        check("ovf_clear", sr, 32'h201);
        atomic_set = 1; atomic_clear = 1;
        step(); clear_inputs();
        check("atomic_set_wins", {31'b0, atomic_flag}, 32'h1);
        wb_fpcsr_set = 1; wb_fpcsr = 12'h0A5;
        step(); clear_inputs();
        check("fpcsr_load", 32'(fpcsr), 32'h0A5);
        wb_fpcsr = 12'h3FF;
        step(); clear_inputs();
        check("fpcsr_hold", 32'(fpcsr), 32'h0A5);

        // Illegal beats trap; the write is suppressed; flush-cycle inputs ignored
        excepts_en = 1; exc.illegal = 1; exc.trap = 1; pc_wb = 32'h1000;
        wb_rf_wb = 1; wb_rfd_adr = 3; wb_result = 32'h55;
        exp_redir.push_back('{pc: 32'h700, epcr: 32'h1000, sr: 32'h201, esr: 32'h201});
        step(); clear_inputs();
        wb_rf_wb = 1; wb_rfd_adr = 4; flag_clear = 1; wb_op_rfe = 1;
        step(); clear_inputs();
        check("atomic_cleared_by_exc", {31'b0, atomic_flag}, 32'h0);
        check("flush_cycle_ignored", sr, 32'h201);

        // Syscall in delay slot, then a plain syscall
        excepts_en = 1; exc.syscall = 1; wb_delay_slot = 1; pc_wb = 32'h2004;
        event_cycle('{pc: 32'hC00, epcr: 32'h2000, sr: 32'h2201, esr: 32'h201});
        excepts_en = 1; exc.syscall = 1; pc_wb = 32'h2100;
        event_cycle('{pc: 32'hC00, epcr: 32'h2104, sr: 32'h201, esr: 32'h2201});

        // Exceptions disabled: the write commits and nothing redirects
        exc.illegal = 1; wb_rf_wb = 1; wb_rfd_adr = 7; wb_result = 32'h1234;
        exp_wr.push_back('{adr: 7, dat: 32'h1234});
        step(); clear_inputs();

        // Trap sets up ESR/EPCR, F cleared, then RFE restores
        excepts_en = 1; exc.trap = 1; pc_wb = 32'h3000;
        event_cycle('{pc: 32'hE00, epcr: 32'h3000, sr: 32'h201, esr: 32'h201});
        flag_clear = 1;
        step(); clear_inputs();
        check("flag_clear", sr, 32'h001);
        wb_op_rfe = 1;
        event_cycle('{pc: 32'h3000, epcr: 32'h3000, sr: 32'h201, esr: 32'h201});

        // Exception coincident with RFE: exception wins
        excepts_en = 1; exc.dbus = 1; wb_op_rfe = 1; pc_wb = 32'h4000;
        event_cycle('{pc: 32'h200, epcr: 32'h4000, sr: 32'h201, esr: 32'h201});

        // Priority table, issued back to back
        for (int i = 0; i < 8; i++) pv[i] = '0;
        pv[0].dpagefault = 1; pv[0].align      = 1; po[0] = 32'h300;
        pv[1].itlb_miss  = 1; pv[1].ibus_align = 1; po[1] = 32'hA00;
        pv[2].ipagefault = 1; pv[2].illegal    = 1; po[2] = 32'h400;
        pv[3].ibus_err   = 1; pv[3].trap       = 1; po[3] = 32'h200;
        pv[4].dtlb_miss  = 1; pv[4].trap       = 1; po[4] = 32'h900;
        pv[5].align      = 1; pv[5].dbus       = 1; po[5] = 32'h600;
        pv[6].syscall    = 1; pv[6].dtlb_miss  = 1; po[6] = 32'hC00;
        pv[7].illegal    = 1; pv[7].syscall    = 1; po[7] = 32'h700;
        for (int i = 0; i < 8; i++) begin
            pc = 32'h5000 + 32'(i) * 32'h10;
            excepts_en = 1; exc = pv[i]; pc_wb = pc;
            event_cycle('{pc: po[i], epcr: (i == 6) ? pc + 32'h4 : pc, sr: 32'h201, esr: 32'h201});
        end

        // Reset during the flush cycle aborts it at once
        excepts_en = 1; exc.trap = 1; pc_wb = 32'h6000;
        step(); clear_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_mid_flush_flush", {31'b0, pipeline_flush}, 32'h0);
        check("rst_mid_flush_redirect", {31'b0, redirect}, 32'h0);
        check("rst_mid_flush_sr", sr, 32'h1);
        check("rst_mid_flush_pc", redirect_pc, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("no_redirect_after_rst", {31'b0, redirect}, 32'h0);

        check("wr_queue_drained", 32'(exp_wr.size()), 32'h0);
        check("redir_queue_drained", 32'(exp_redir.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
